// File: rtl/pe_v4_pkg.sv
// rtl/pe_v4_pkg.sv - opcode classes/funcs, status bits and divider FSM states for pe_core_v4
package pe_v4_pkg;

  localparam logic [6:0] CLS_ARITH = 7'b0000001;
  localparam logic [6:0] CLS_ACT   = 7'b0000010;
  localparam logic [6:0] CLS_COMP  = 7'b0010000;

  localparam logic [4:0] FA_ADD     = 5'b00001;
  localparam logic [4:0] FA_SUB     = 5'b00010;
  localparam logic [4:0] FA_MUL     = 5'b00011;
  localparam logic [4:0] FA_DIV     = 5'b00100;
  localparam logic [4:0] FA_MAD     = 5'b00101;
  localparam logic [4:0] FA_MAC     = 5'b00110;
  localparam logic [4:0] FA_ACC_CLR = 5'b00111;
  localparam logic [4:0] FA_REM     = 5'b01000;
  localparam logic [4:0] FA_AND     = 5'b01001;
  localparam logic [4:0] FA_OR      = 5'b01010;
  localparam logic [4:0] FA_XOR     = 5'b01011;
  localparam logic [4:0] FA_SHL     = 5'b01100;
  localparam logic [4:0] FA_SHR     = 5'b01101;

  localparam logic [4:0] FV_FMA  = 5'b00001;
  localparam logic [4:0] FV_RELU = 5'b01011;
  localparam logic [4:0] FV_ABS  = 5'b01101;
  localparam logic [4:0] FV_NEG  = 5'b01110;
  localparam logic [4:0] FV_MIN  = 5'b10000;
  localparam logic [4:0] FV_MAX  = 5'b10001;

  localparam logic [4:0] FC_EQ  = 5'b00001;
  localparam logic [4:0] FC_NE  = 5'b00010;
  localparam logic [4:0] FC_LTU = 5'b00011;
  localparam logic [4:0] FC_LEU = 5'b00100;
  localparam logic [4:0] FC_GTU = 5'b00101;
  localparam logic [4:0] FC_GEU = 5'b00110;
  localparam logic [4:0] FC_LTS = 5'b10011;
  localparam logic [4:0] FC_LES = 5'b10100;
  localparam logic [4:0] FC_GTS = 5'b10101;
  localparam logic [4:0] FC_GES = 5'b10110;

  localparam int ST_ILLEGAL = 0;
  localparam int ST_DIV0    = 1;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic is_divrem(input logic [6:0] cls, input logic [4:0] fn);
    return (cls == CLS_ARITH) && ((fn == FA_DIV) || (fn == FA_REM));
  endfunction

endpackage

// File: rtl/pe_core_v4_if.sv
// rtl/pe_core_v4_if.sv - command/result handshake bundle between dispatcher, PE and writeback
interface pe_core_v4_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       opcode;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;
  logic [DATA_W-1:0] op3;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic [1:0]        status;
  logic              busy;

  modport master (
    output in_valid, opcode, op1, op2, op3, out_ready,
    input  in_ready, out_valid, result, status, busy
  );

  modport slave (
    input  in_valid, opcode, op1, op2, op3, out_ready,
    output in_ready, out_valid, result, status, busy
  );
endinterface

// File: rtl/pe_v4_divider.sv
// rtl/pe_v4_divider.sv - restoring unsigned divider, one quotient bit per cycle
module pe_v4_divider
  import pe_v4_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_ack,
  input  logic [DATA_W-1:0] i_dividend,
  input  logic [DATA_W-1:0] i_divisor,
  output logic              o_done,
  output logic [DATA_W-1:0] o_quotient,
  output logic [DATA_W-1:0] o_remainder,
  output logic              o_div0,
  output logic              o_busy
);

  localparam int CNT_W = $clog2(DATA_W);

  div_state_e        r_state;
  div_state_e        w_state_nxt;
  logic [DATA_W-1:0] r_quo;
  logic [DATA_W-1:0] r_rem;
  logic [DATA_W-1:0] r_dvs;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_div0;
  logic [DATA_W:0]   w_trial;
  logic [DATA_W-1:0] w_quo_nxt;
  logic [DATA_W-1:0] w_rem_nxt;
  logic              w_start_run;

  assign w_start_run = i_start && (i_divisor != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DIV_IDLE;
      r_quo   <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_div0  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (i_start) begin
        r_dvs  <= i_divisor;
        r_cnt  <= '0;
        r_div0 <= (i_divisor == '0);
        // Divide-by-zero resolves at load time: all-ones quotient, dividend as remainder.
        r_quo  <= (i_divisor == '0) ? '1 : i_dividend;
        r_rem  <= (i_divisor == '0) ? i_dividend : '0;
      end else if (r_state == DIV_RUN) begin
        r_quo <= w_quo_nxt;
        r_rem <= w_rem_nxt;
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_trial = {r_rem, r_quo[DATA_W-1]} - {1'b0, r_dvs};
    if (w_trial[DATA_W]) begin
      w_rem_nxt = {r_rem[DATA_W-2:0], r_quo[DATA_W-1]};
      w_quo_nxt = {r_quo[DATA_W-2:0], 1'b0};
    end else begin
      w_rem_nxt = w_trial[DATA_W-1:0];
      w_quo_nxt = {r_quo[DATA_W-2:0], 1'b1};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DIV_IDLE: if (w_start_run) w_state_nxt = DIV_RUN;
      DIV_RUN:  if (r_cnt == CNT_W'(DATA_W - 1)) w_state_nxt = DIV_DONE;
      // A following DIV/REM may be accepted in the very cycle this one retires.
      DIV_DONE: if (i_ack) w_state_nxt = w_start_run ? DIV_RUN : DIV_IDLE;
      default:  w_state_nxt = DIV_IDLE;
    endcase
  end

  assign o_done      = (r_state == DIV_DONE) || ((r_state == DIV_IDLE) && r_div0);
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;
  assign o_div0      = r_div0;
  assign o_busy      = (r_state != DIV_IDLE);

endmodule

// File: rtl/pe_core_v4.sv
// rtl/pe_core_v4.sv - two-stage stallable PE: ALU, activation, compare, iterative divide, MAC accumulator
module pe_core_v4
  import pe_v4_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 2 * DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  pe_core_v4_if.slave  io_pe
);

  localparam int SH_W = $clog2(DATA_W);

  logic              r_s1_valid;
  logic [6:0]        r_s1_cls;
  logic [4:0]        r_s1_fn;
  logic [DATA_W-1:0] r_s1_op1;
  logic [DATA_W-1:0] r_s1_op2;
  logic [DATA_W-1:0] r_s1_op3;
  logic              r_s2_valid;
  logic [DATA_W-1:0] r_s2_result;
  logic [1:0]        r_s2_status;
  logic [ACC_W-1:0]  r_acc;

  logic              w_is_div;
  logic              w_op_ready;
  logic              w_s1_advance;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_div_start;
  logic              w_div_done;
  logic              w_div_div0;
  logic              w_div_busy;
  logic [DATA_W-1:0] w_div_quo;
  logic [DATA_W-1:0] w_div_rem;
  logic [DATA_W-1:0] w_prod;
  logic [DATA_W-1:0] w_mad;
  logic [ACC_W-1:0]  w_mac_sum;
  logic [DATA_W-1:0] w_result;
  logic [1:0]        w_status;
  logic              w_illegal;
  logic [ACC_W-1:0]  w_acc_nxt;
  logic              w_acc_we;
  logic              w_unused_opcode;

  assign w_unused_opcode = ^io_pe.opcode[19:0];

  assign w_is_div     = is_divrem(r_s1_cls, r_s1_fn);
  assign w_op_ready   = !w_is_div || w_div_done;
  assign w_s1_advance = r_s1_valid && (!r_s2_valid || io_pe.out_ready) && w_op_ready;
  assign w_in_ready   = !rst && (!r_s1_valid || w_s1_advance);
  assign w_accept     = io_pe.in_valid && w_in_ready;
  assign w_div_start  = w_accept && is_divrem(io_pe.opcode[31:25], io_pe.opcode[24:20]);

  pe_v4_divider #(
    .DATA_W (DATA_W)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_div_start),
    .i_ack       (w_s1_advance),
    .i_dividend  (io_pe.op1),
    .i_divisor   (io_pe.op2),
    .o_done      (w_div_done),
    .o_quotient  (w_div_quo),
    .o_remainder (w_div_rem),
    .o_div0      (w_div_div0),
    .o_busy      (w_div_busy)
  );

  assign w_prod    = r_s1_op1 * r_s1_op2;
  assign w_mad     = w_prod + r_s1_op3;
  assign w_mac_sum = r_acc + (ACC_W'(r_s1_op1) * ACC_W'(r_s1_op2));

  always_comb begin
    w_result  = '0;
    w_illegal = 1'b0;
    w_acc_nxt = r_acc;
    w_acc_we  = 1'b0;
    case (r_s1_cls)
      CLS_ARITH: begin
        case (r_s1_fn)
          FA_ADD:     w_result = r_s1_op1 + r_s1_op2;
          FA_SUB:     w_result = r_s1_op1 - r_s1_op2;
          FA_MUL:     w_result = w_prod;
          FA_DIV:     w_result = w_div_quo;
          FA_MAD:     w_result = w_mad;
          FA_MAC: begin
            w_acc_nxt = w_mac_sum;
            w_acc_we  = 1'b1;
            w_result  = w_mac_sum[DATA_W-1:0];
          end
          FA_ACC_CLR: begin
            w_acc_nxt = '0;
            w_acc_we  = 1'b1;
          end
          FA_REM:     w_result = w_div_rem;
          FA_AND:     w_result = r_s1_op1 & r_s1_op2;
          FA_OR:      w_result = r_s1_op1 | r_s1_op2;
          FA_XOR:     w_result = r_s1_op1 ^ r_s1_op2;
          FA_SHL:     w_result = r_s1_op1 << r_s1_op2[SH_W-1:0];
          FA_SHR:     w_result = r_s1_op1 >> r_s1_op2[SH_W-1:0];
          default:    w_illegal = 1'b1;
        endcase
      end
      CLS_ACT: begin
        case (r_s1_fn)
          FV_FMA:  w_result = w_mad;
          FV_RELU: w_result = r_s1_op1[DATA_W-1] ? '0 : r_s1_op1;
          FV_ABS:  w_result = r_s1_op1[DATA_W-1] ? ('0 - r_s1_op1) : r_s1_op1;
          FV_NEG:  w_result = '0 - r_s1_op1;
          FV_MIN:  w_result = ($signed(r_s1_op1) < $signed(r_s1_op2)) ? r_s1_op1 : r_s1_op2;
          FV_MAX:  w_result = ($signed(r_s1_op1) > $signed(r_s1_op2)) ? r_s1_op1 : r_s1_op2;
          default: w_illegal = 1'b1;
        endcase
      end
      CLS_COMP: begin
        case (r_s1_fn)
          FC_EQ:   w_result = DATA_W'(r_s1_op1 == r_s1_op2);
          FC_NE:   w_result = DATA_W'(r_s1_op1 != r_s1_op2);
          FC_LTU:  w_result = DATA_W'(r_s1_op1 <  r_s1_op2);
          FC_LEU:  w_result = DATA_W'(r_s1_op1 <= r_s1_op2);
          FC_GTU:  w_result = DATA_W'(r_s1_op1 >  r_s1_op2);
          FC_GEU:  w_result = DATA_W'(r_s1_op1 >= r_s1_op2);
          FC_LTS:  w_result = DATA_W'($signed(r_s1_op1) <  $signed(r_s1_op2));
          FC_LES:  w_result = DATA_W'($signed(r_s1_op1) <= $signed(r_s1_op2));
          FC_GTS:  w_result = DATA_W'($signed(r_s1_op1) >  $signed(r_s1_op2));
          FC_GES:  w_result = DATA_W'($signed(r_s1_op1) >= $signed(r_s1_op2));
          default: w_illegal = 1'b1;
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_status              = '0;
    w_status[ST_ILLEGAL]  = w_illegal;
    w_status[ST_DIV0]     = w_is_div && w_div_div0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_cls    <= '0;
      r_s1_fn     <= '0;
      r_s1_op1    <= '0;
      r_s1_op2    <= '0;
      r_s1_op3    <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_status <= '0;
      r_acc       <= '0;
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_cls   <= io_pe.opcode[31:25];
        r_s1_fn    <= io_pe.opcode[24:20];
        r_s1_op1   <= io_pe.op1;
        r_s1_op2   <= io_pe.op2;
        r_s1_op3   <= io_pe.op3;
      end else if (w_s1_advance) begin
        r_s1_valid <= 1'b0;
      end
      // The accumulator commits only with the result, so a stalled MAC never double-counts.
      if (w_s1_advance) begin
        r_s2_valid  <= 1'b1;
        r_s2_result <= w_result;
        r_s2_status <= w_status;
        if (w_acc_we) r_acc <= w_acc_nxt;
      end else if (io_pe.out_ready) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  assign io_pe.in_ready  = w_in_ready;
  assign io_pe.out_valid = r_s2_valid;
  assign io_pe.result    = r_s2_result;
  assign io_pe.status    = r_s2_status;
  assign io_pe.busy      = r_s1_valid || r_s2_valid || w_div_busy;

endmodule

// File: tb/tb_pe_core_v4.sv
// tb/tb_pe_core_v4.sv - directed table-driven bench for pe_core_v4
module tb_pe_core_v4;

  localparam int DW = 32;

  localparam logic [6:0] C_AR = 7'b0000001;
  localparam logic [6:0] C_AC = 7'b0000010;
  localparam logic [6:0] C_CP = 7'b0010000;

  typedef struct {
    logic [6:0]  cls;
    logic [4:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] exp_res;
    logic [1:0]  exp_st;
    int          exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pe_core_v4_if #(.DATA_W(DW)) pe_if ();

  pe_core_v4 #(.DATA_W(DW), .ACC_W(2 * DW)) dut (
    .clk   (clk),
    .rst   (rst),
    .io_pe (pe_if)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [33:0] mon_q[$];
  vec_t vecs[$];

  always @(negedge clk)
    if (!rst && pe_if.out_valid && pe_if.out_ready)
      mon_q.push_back({pe_if.status, pe_if.result});

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic add(input logic [6:0] cls, input logic [4:0] fn, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] c, input logic [31:0] r,
                     input logic [1:0] s, input int l);
    vec_t v;
    v.cls = cls; v.fn = fn; v.a = a; v.b = b; v.c = c;
    v.exp_res = r; v.exp_st = s; v.exp_lat = l;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [6:0] cls, input logic [4:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c);
    pe_if.in_valid = 1'b1;
    pe_if.opcode   = {cls, fn, 20'hA5A5A};
    pe_if.op1      = a;
    pe_if.op2      = b;
    pe_if.op3      = c;
  endtask

  task automatic do_op(input logic [6:0] cls, input logic [4:0] fn, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] c,
                       output logic [31:0] res, output logic [1:0] st, output int lat);
    int k;
    @(posedge clk); #1;
    drive(cls, fn, a, b, c);
    k = 0;
    @(negedge clk);
    while (!pe_if.in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      n_chk++;
      n_err++;
      $display("FAIL accept_timeout: got=in_ready 0 expected=in_ready 1");
    end
    @(posedge clk); #1;
    pe_if.in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!pe_if.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = pe_if.result;
    st  = pe_if.status;
  endtask

  logic [31:0] res;
  logic [1:0]  st;
  int          lat;
  logic [6:0]  s_cls[3];
  logic [4:0]  s_fn[3];
  logic [31:0] s_a[3];
  logic [31:0] s_b[3];
  logic [31:0] s_exp[3];
  int          idx;
  int          seen;

  initial begin
    pe_if.in_valid  = 1'b0;
    pe_if.opcode    = '0;
    pe_if.op1       = '0;
    pe_if.op2       = '0;
    pe_if.op3       = '0;
    pe_if.out_ready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(pe_if.in_ready), 32'd0);
    check("rst_out_valid", 32'(pe_if.out_valid), 32'd0);
    check("rst_result", pe_if.result, 32'd0);
    check("rst_status", 32'(pe_if.status), 32'd0);
    check("rst_busy", 32'(pe_if.busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(pe_if.in_ready), 32'd1);

    // back-to-back ADD, SUB, XOR: results on consecutive cycles from t+2
    s_cls = '{C_AR, C_AR, C_AR};
    s_fn  = '{5'b00001, 5'b00010, 5'b01011};
    s_a   = '{32'd5, 32'd3, 32'h0000F0F0};
    s_b   = '{32'd7, 32'd5, 32'h00000FF0};
    s_exp = '{32'd12, 32'hFFFFFFFE, 32'h0000FF00};
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (c < 3) drive(s_cls[c], s_fn[c], s_a[c], s_b[c], 32'd0);
      else pe_if.in_valid = 1'b0;
      @(negedge clk);
      if (c < 3) check($sformatf("b2b_in_ready_c%0d", c), 32'(pe_if.in_ready), 32'd1);
      check($sformatf("b2b_out_valid_c%0d", c), 32'(pe_if.out_valid), (c >= 2 && c <= 4) ? 32'd1 : 32'd0);
      if (c >= 2 && c <= 4) check($sformatf("b2b_result_c%0d", c), pe_if.result, s_exp[c-2]);
    end

    // table of single commands
    add(C_AR, 5'b00001, 32'd5, 32'd7, 0, 32'd12, 2'b00, 2);
    add(C_AR, 5'b00010, 32'd3, 32'd5, 0, 32'hFFFFFFFE, 2'b00, 2);
    add(C_AR, 5'b00011, 32'h00010000, 32'h00010001, 0, 32'h00010000, 2'b00, 2);
    add(C_AR, 5'b00101, 32'd3, 32'd4, 32'd5, 32'd17, 2'b00, 2);
    add(C_AR, 5'b01001, 32'h0000F0F0, 32'h0000FF00, 0, 32'h0000F000, 2'b00, 2);
    add(C_AR, 5'b01010, 32'h00000F0F, 32'h0000F000, 0, 32'h0000FF0F, 2'b00, 2);
    add(C_AR, 5'b01100, 32'd1, 32'd35, 0, 32'd8, 2'b00, 2);
    add(C_AR, 5'b01101, 32'h80000000, 32'd31, 0, 32'd1, 2'b00, 2);
    add(C_AR, 5'b00100, 32'd100, 32'd7, 0, 32'd14, 2'b00, 34);
    add(C_AR, 5'b01000, 32'd100, 32'd7, 0, 32'd2, 2'b00, 34);
    add(C_AR, 5'b00100, 32'hFFFFFFFF, 32'h00010000, 0, 32'h0000FFFF, 2'b00, 34);
    add(C_AR, 5'b00100, 32'd9, 32'd0, 0, 32'hFFFFFFFF, 2'b10, 2);
    add(C_AR, 5'b01000, 32'd9, 32'd0, 0, 32'd9, 2'b10, 2);
    add(C_AR, 5'b00110, 32'd3, 32'd4, 0, 32'd12, 2'b00, 2);
    add(C_AR, 5'b00110, 32'd5, 32'd6, 0, 32'd42, 2'b00, 2);
    add(C_AR, 5'b00111, 32'd9, 32'd9, 0, 32'd0, 2'b00, 2);
    add(C_AR, 5'b00110, 32'd2, 32'd2, 0, 32'd4, 2'b00, 2);
    add(C_AR, 5'b00110, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'd5, 2'b00, 2);
    add(C_AR, 5'b00110, 32'd0, 32'd0, 0, 32'd5, 2'b00, 2);
    add(C_CP, 5'b00011, 32'hFFFFFFFF, 32'd1, 0, 32'd0, 2'b00, 2);
    add(C_CP, 5'b10011, 32'hFFFFFFFF, 32'd1, 0, 32'd1, 2'b00, 2);
    add(C_CP, 5'b00001, 32'd5, 32'd5, 0, 32'd1, 2'b00, 2);
    add(C_CP, 5'b00010, 32'd5, 32'd5, 0, 32'd0, 2'b00, 2);
    add(C_CP, 5'b00100, 32'd5, 32'd5, 0, 32'd1, 2'b00, 2);
    add(C_CP, 5'b00101, 32'd6, 32'd5, 0, 32'd1, 2'b00, 2);
    add(C_CP, 5'b00110, 32'd4, 32'd5, 0, 32'd0, 2'b00, 2);
    add(C_CP, 5'b10110, 32'hFFFFFFFF, 32'd0, 0, 32'd0, 2'b00, 2);
    add(C_CP, 5'b10101, 32'd1, 32'hFFFFFFFF, 0, 32'd1, 2'b00, 2);
    add(C_CP, 5'b10100, 32'h80000000, 32'h7FFFFFFF, 0, 32'd1, 2'b00, 2);
    add(C_AC, 5'b10001, 32'hFFFFFFFD, 32'd2, 0, 32'd2, 2'b00, 2);
    add(C_AC, 5'b10000, 32'hFFFFFFFD, 32'd2, 0, 32'hFFFFFFFD, 2'b00, 2);
    add(C_AC, 5'b01011, 32'hFFFFFFFD, 0, 0, 32'd0, 2'b00, 2);
    add(C_AC, 5'b01011, 32'd7, 0, 0, 32'd7, 2'b00, 2);
    add(C_AC, 5'b01101, 32'hFFFFFFFB, 0, 0, 32'd5, 2'b00, 2);
    add(C_AC, 5'b01101, 32'h80000000, 0, 0, 32'h80000000, 2'b00, 2);
    add(C_AC, 5'b01110, 32'd1, 0, 0, 32'hFFFFFFFF, 2'b00, 2);
    add(C_AC, 5'b00001, 32'd2, 32'd3, 32'd4, 32'd10, 2'b00, 2);
    add(7'h7F, 5'b00001, 32'd1, 32'd2, 0, 32'd0, 2'b01, 2);
    add(C_AR, 5'b00000, 32'd1, 32'd2, 0, 32'd0, 2'b01, 2);
    add(C_CP, 5'b10001, 32'd1, 32'd2, 0, 32'd0, 2'b01, 2);

    foreach (vecs[i]) begin
      do_op(vecs[i].cls, vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].c, res, st, lat);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
      check($sformatf("vec%0d_status", i), 32'(st), 32'(vecs[i].exp_st));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
    end

    // output stall with three commands offered: ACC_CLR, MAC(10,10), MAC(3,3)
    s_cls = '{C_AR, C_AR, C_AR};
    s_fn  = '{5'b00111, 5'b00110, 5'b00110};
    s_a   = '{32'd0, 32'd10, 32'd3};
    s_b   = '{32'd0, 32'd10, 32'd3};
    s_exp = '{32'd0, 32'd100, 32'd109};
    @(posedge clk); #1;
    mon_q.delete();
    idx = 0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      pe_if.out_ready = (c >= 6);
      if (idx < 3) drive(s_cls[idx], s_fn[idx], s_a[idx], s_b[idx], 32'd0);
      else pe_if.in_valid = 1'b0;
      @(negedge clk);
      if (c >= 2 && c <= 5) begin
        check($sformatf("stall_in_ready_c%0d", c), 32'(pe_if.in_ready), 32'd0);
        check($sformatf("stall_out_valid_c%0d", c), 32'(pe_if.out_valid), 32'd1);
        check($sformatf("stall_result_c%0d", c), pe_if.result, s_exp[0]);
      end
      if (pe_if.in_valid && pe_if.in_ready) idx++;
    end
    pe_if.in_valid  = 1'b0;
    pe_if.out_ready = 1'b1;
    check("stall_delivered", 32'(mon_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall_order%0d", i), (i < mon_q.size()) ? mon_q[i][31:0] : 32'hxxxxxxxx, s_exp[i]);
    end
    do_op(C_AR, 5'b00110, 32'd0, 32'd0, 32'd0, res, st, lat);
    check("stall_acc_once", res, 32'd109);

    // reset during division cycle 10
    @(posedge clk); #1;
    mon_q.delete();
    drive(C_AR, 5'b00100, 32'd100, 32'd7, 32'd0);
    @(negedge clk);
    check("rdiv_accept", 32'(pe_if.in_ready), 32'd1);
    @(posedge clk); #1;
    pe_if.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("rdiv_in_ready_busy", 32'(pe_if.in_ready), 32'd0);
    check("rdiv_busy", 32'(pe_if.busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rdiv_in_ready_rst", 32'(pe_if.in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rdiv_busy_after", 32'(pe_if.busy), 32'd0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (pe_if.out_valid) seen++;
      @(negedge clk);
    end
    check("rdiv_no_output", 32'(seen), 32'd0);
    check("rdiv_mon_empty", 32'(mon_q.size()), 32'd0);
    do_op(C_AR, 5'b00110, 32'd1, 32'd1, 32'd0, res, st, lat);
    check("rdiv_acc_cleared", res, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pe_core_v4.md
# pe_core_v4

Parametrised successor processing element: integer ALU, activation and compare unit with valid/ready handshakes on both sides, a stallable two-stage pipeline, an iterative multi-cycle divider and a persistent MAC accumulator. Sits between the operand dispatcher and the result writeback network. Uses the same opcode encoding as the previous PE generation: [31:25] class, [24:20] func. Output backpressure is honoured without dropping results.

## Interface
- DATA_W, 32, operand/result width (≥8)
- ACC_W, 2*DATA_W, accumulator width; result returns acc[DATA_W-1:0]
- clk  in  1  clock; one clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  command valid
- in_ready  out  1  command accepted when in_valid && in_ready
- opcode  in  32  [31:25] class, [24:20] func, rest ignored
- op1, op2, op3  in  DATA_W each  operands
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- result  out  DATA_W  result data
- status  out  2  bit0 illegal op, bit1 divide-by-zero; valid with out_valid
- busy  out  1  any stage occupied or divider running

## Operation
- Class ARITH 0000001: ADD 00001, SUB 00010, MUL 00011 (low DATA_W bits), DIV 00100 (unsigned quotient), MAD 00101 (op1*op2+op3, truncated), MAC 00110 (acc += op1*op2 zero-extended to ACC_W; result = new acc low bits), ACC_CLR 00111 (acc=0, result 0), REM 01000 (unsigned remainder), AND 01001, OR 01010, XOR 01011, SHL 01100, SHR 01101 (logical); shift amount op2[$clog2(DATA_W)-1:0].
- Class ACT 0000010 (two's complement signed): FMA 00001 (=MAD), RELU 01011, ABS 01101 (ABS(min neg)=min neg), NEG 01110, MIN 10000, MAX 10001.
- Class COMP 0010000: EQ 00001, NE 00010, LT 00011, LE 00100, GT 00101, GE 00110 unsigned; func | 10000 (10011..10110) = signed LT/LE/GT/GE; result 1 or 0.
- Any other class/func: result 0, status[0]=1, still emitted (never silently dropped).
- DIV/REM: restoring divider, one quotient bit per cycle, DATA_W iterations. Divisor 0: quotient all-ones, remainder = op1, status[1]=1, completes in one cycle (no iteration).
- Stage S1: command register. Stage S2: output register (result, status).
- S1 advances to S2 when S2 empty or out_ready=1 this cycle, and the op is single-cycle or the divider has finished.
- in_ready = !s1_valid || s1_advance (accept same cycle as S1 drains).
- Accumulator updates only when MAC/ACC_CLR advances S1→S2, never on stall.
- FSM (divider): IDLE → DIV_RUN on DIV/REM entering S1 with nonzero divisor; DIV_RUN counts DATA_W cycles → DIV_DONE; DIV_DONE → IDLE when S1 advances.

## Timing
- Reset: in_ready=0 during rst, 1 the cycle after; out_valid=0, result=0, status=0, busy=0, acc=0, FSM IDLE.
- Single-cycle op: accepted cycle t → out_valid at t+2, assuming no stall. Throughput 1/cycle with out_ready held high.
- DIV/REM nonzero divisor: accepted t → out_valid at t+DATA_W+2; in_ready=0 meanwhile (S1 occupied).
- out_valid && !out_ready: result, status held stable; S1 holds; in_ready drops once S1 full.
- Simultaneous out-handshake and S1 advance: S2 replaced same cycle, no bubble.
- rst mid-division or mid-stall: all in-flight work discarded, acc cleared; no partial result emitted.

## Structure
- Package pe_v4_pkg: class and func localparams, status bit indices, divider FSM state enum.
- Sub-module pe_v4_divider (start, dividend, divisor → done, quotient, remainder, div0), DATA_W parameter; everything else in pe_core_v4.

## Test plan
- Back-to-back ADD 5+7, SUB 3-5, XOR 0xF0F0^0x0FF0 with out_ready=1 → 12, 0xFFFFFFFE, 0x0000FF00 on consecutive cycles starting t+2.
- DIV 100/7 then REM 100/7 → 14 at t+34, 2 next op; DIV 9/0 → 0xFFFFFFFF, status=2'b10 at t+2.
- MAC sequence (3,4),(5,6) → 12, 42; ACC_CLR → 0; MAC (2,2) → 4.
- Signed vs unsigned LT on 0xFFFFFFFF,1 → func 00011 gives 0, func 10011 gives 1; MAX signed (-3,2) → 2.
- out_ready low 5 cycles with 3 commands offered → result stable, in_ready 0 after S1 fills, all 3 results delivered in order with no loss, acc updated once per MAC.
- rst asserted at divider cycle 10 → out_valid never asserts for that op, busy=0 next cycle; illegal class 0x7F → result 0, status=2'b01.
